mux_stream_sel: RTL and testbench

//   Parametrised N-channel, W-bit select mux with a valid/ready request port and a
//   2-entry output FIFO. On request acceptance, the selected channel is sampled.
//   Out-of-range selects are flagged and counted rather than silently defaulted.
//   It sits between the channel-select control path and downstream consumers

---
 rtl/mux_stream_sel_if.sv | 24 ++
 rtl/mux_stream_sel.sv | 88 ++++++++
 tb/tb_mux_stream_sel.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mux_stream_sel_if.sv
// Request/response handshake bundle for mux_stream_sel.
// The master side issues selects and consumes FIFO output; the slave side is the mux.
interface mux_stream_sel_if #(
    parameter int SEL_W = 5,
    parameter int WIDTH = 2
);
    logic             req_valid;
    logic [SEL_W-1:0] req_sel;
    logic             req_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_err;
    logic             out_ready;

    modport master (
        output req_valid, req_sel, out_ready,
        input  req_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  req_valid, req_sel, out_ready,
        output req_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/mux_stream_sel.sv
// N-channel select mux feeding a 2-entry output FIFO; out-of-range selects return
// DEFAULT_VAL flagged as errors and are tallied in a saturating counter.
module mux_stream_sel #(
    parameter int               N_INP       = 31,
    parameter int               WIDTH       = 2,
    parameter int               SEL_W       = 5,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
    parameter int               ERR_CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_INP*WIDTH-1:0] inp_bus,
    mux_stream_sel_if.slave        bus,
    output logic [ERR_CNT_W-1:0]   err_cnt
);

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_data;
    logic             push_err;
    logic [1:0]       count;
    logic             rd_ptr;
    logic             wr_ptr;
    logic [WIDTH-1:0] mem_data [2];
    logic             mem_err  [2];
    logic [WIDTH-1:0] last_data;
    logic             last_err;

    // Decode the selected channel; each select value matches at most one channel.
    always_comb begin
        push_data = DEFAULT_VAL;
        push_err  = 1'b1;
        for (int k = 0; k < N_INP; k++) begin
            if (bus.req_sel == SEL_W'(k)) begin
                push_data = inp_bus[k*WIDTH +: WIDTH];
                push_err  = 1'b0;
            end
        end
    end

    assign bus.req_ready = !rst && (count < 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign push          = bus.req_valid && bus.req_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    // When empty, the output shows the most recently popped entry.
    assign bus.out_data  = bus.out_valid ? mem_data[rd_ptr] : last_data;
    assign bus.out_err   = bus.out_valid ? mem_err[rd_ptr]  : last_err;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= push_data;
            mem_err[wr_ptr]  <= push_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= 2'd0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            err_cnt   <= '0;
            last_data <= '0;
            last_err  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
                if (push_err)
                    err_cnt <= sat_inc(err_cnt);
            end
            if (pop) begin
                rd_ptr    <= ~rd_ptr;
                last_data <= mem_data[rd_ptr];
                last_err  <= mem_err[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_stream_sel.sv
// Randomized scoreboard bench for mux_stream_sel against a queue-based reference model.
module tb_mux_stream_sel;
    localparam int N       = 31;
    localparam int W       = 2;
    localparam int SW      = 5;
    localparam int EW      = 8;
    localparam int ERR_MAX = 255;
    localparam logic [W-1:0] DEF = '0;

    typedef struct {
        logic [W-1:0] d;
        logic         e;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N*W-1:0]   inp_bus;
    logic [EW-1:0]    err_cnt;
    logic [W-1:0]     chan [N];
    bit               rnd_inp = 1'b0;

    int   vectors     = 0;
    int   miscompares = 0;
    ent_t q[$];
    ent_t last_pop;
    int   exp_err     = 0;
    bit   rst_prev    = 1'b0;

    mux_stream_sel_if #(.SEL_W(SW), .WIDTH(W)) bus_if ();

    mux_stream_sel #(
        .N_INP(N), .WIDTH(W), .SEL_W(SW), .DEFAULT_VAL(DEF), .ERR_CNT_W(EW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .inp_bus(inp_bus),
        .bus(bus_if),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        inp_bus = '0;
        for (int k = 0; k < N; k++) inp_bus[k*W +: W] = chan[k];
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: samples on the falling edge, away from the active edge.
    initial begin
        ent_t e;
        last_pop = '{d: '0, e: 1'b0};
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_req_ready", int'(bus_if.req_ready), 0);
                if (rst_prev) begin
                    chk("rst_out_valid", int'(bus_if.out_valid), 0);
                    chk("rst_out_data", int'(bus_if.out_data), 0);
                    chk("rst_out_err", int'(bus_if.out_err), 0);
                    chk("rst_err_cnt", int'(err_cnt), 0);
                end
                q.delete();
                exp_err  = 0;
                last_pop = '{d: '0, e: 1'b0};
            end else begin
                chk("out_valid", int'(bus_if.out_valid), int'(q.size() != 0));
                chk("req_ready", int'(bus_if.req_ready), int'(q.size() < 2));
                chk("err_cnt", int'(err_cnt), exp_err);
                if (q.size() != 0) begin
                    chk("head_data", int'(bus_if.out_data), int'(q[0].d));
                    chk("head_err", int'(bus_if.out_err), int'(q[0].e));
                end else begin
                    chk("idle_data", int'(bus_if.out_data), int'(last_pop.d));
                    chk("idle_err", int'(bus_if.out_err), int'(last_pop.e));
                end
                if (bus_if.out_valid && bus_if.out_ready && q.size() != 0)
                    last_pop = q.pop_front();
                if (bus_if.req_valid && bus_if.req_ready) begin
                    e.e = (int'(bus_if.req_sel) >= N);
                    e.d = e.e ? DEF : chan[bus_if.req_sel];
                    q.push_back(e);
                    if (e.e && exp_err < ERR_MAX) exp_err++;
                end
            end
            rst_prev = rst;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        if (rnd_inp)
            for (int k = 0; k < N; k++) chan[k] = W'($urandom);
    endtask

    task automatic send(input logic [SW-1:0] s);
        int n   = 0;
        bit acc = 1'b0;
        bus_if.req_valid = 1'b1;
        bus_if.req_sel   = s;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus_if.req_ready;
            cycle();
            n++;
        end
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: sel %0d not accepted, expected acceptance", s);
        end
    endtask

    initial begin
        int n;
        for (int k = 0; k < N; k++) chan[k] = W'(k % 4);
        bus_if.req_valid = 1'b0;
        bus_if.req_sel   = '0;
        bus_if.out_ready = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;

        // Sweep every channel back-to-back, then the 12/13 pair.
        for (int s = 0; s < N; s++) send(SW'(s));
        chan[12] = 2'd2;
        chan[13] = 2'd1;
        send(5'd12);
        send(5'd13);
        bus_if.req_valid = 1'b0;
        repeat (3) cycle();

        // Out-of-range then in-range.
        send(5'd31);
        chan[30] = 2'd3;
        send(5'd30);
        bus_if.req_valid = 1'b0;
        repeat (3) cycle();

        // Fill under backpressure, hold a third request, then release.
        chan[1] = 2'd1; chan[2] = 2'd2; chan[3] = 2'd3;
        bus_if.out_ready = 1'b0;
        send(5'd1);
        send(5'd2);
        bus_if.req_sel = 5'd3;
        repeat (4) cycle();
        bus_if.out_ready = 1'b1;
        send(5'd3);
        bus_if.req_valid = 1'b0;
        repeat (3) cycle();

        // Steady push+pop at count=1 with changing inputs.
        rnd_inp = 1'b1;
        send(5'd5);
        for (int i = 0; i < 10; i++) send(SW'($urandom_range(0, N - 1)));
        bus_if.req_valid = 1'b0;
        repeat (3) cycle();

        // Saturate the error counter, then clear it with reset.
        for (int i = 0; i < 300; i++) send(5'd31);
        bus_if.req_valid = 1'b0;
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (2) cycle();

        // Reset while full; no stale entries afterwards.
        bus_if.out_ready = 1'b0;
        send(5'd4);
        send(5'd7);
        bus_if.req_valid = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        bus_if.out_ready = 1'b1;
        cycle();
        send(5'd9);
        bus_if.req_valid = 1'b0;
        repeat (3) cycle();

        // Random traffic including occasional resets.
        for (int i = 0; i < 600; i++) begin
            bus_if.req_valid = ($urandom_range(0, 3) != 0);
            bus_if.req_sel   = SW'($urandom_range(0, 31));
            bus_if.out_ready = ($urandom_range(0, 3) != 0);
            rst              = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;
        bus_if.req_valid = 1'b0;
        bus_if.out_ready = 1'b1;

        n = 0;
        while (q.size() != 0 && n < 20) begin
            cycle();
            n++;
        end
        repeat (2) cycle();
        chk("drain_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
